// File: rtl/coeff_load_sequencer_pkg.sv
// Shared types and constants for the coefficient load sequencer.
// Optional shadow readback RAM is enabled by COEFF_SEQ_SHADOW_EN.
package coeff_seq_pkg;

   localparam int COEFF_ADR_W = 8;
   localparam int COEFF_DAT_W = 18;

   localparam logic CMD_WRITE  = 1'b0;
   localparam logic CMD_UPDATE = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      GAP
   } seq_state_t;

endpackage

// File: rtl/coeff_load_sequencer_if.sv
// Two-requester valid/ready bundle feeding the coefficient sequencer.
// master = requester side, slave = sequencer side.
interface coeff_load_sequencer_if;
   import coeff_seq_pkg::*;

   logic [1:0]               req_valid_i;
   logic [1:0]               req_ready_o;
   logic [1:0]               req_cmd_i;
   logic [2*COEFF_ADR_W-1:0] req_adr_i;
   logic [2*COEFF_DAT_W-1:0] req_dat_i;

   modport master (
      output req_valid_i,
      output req_cmd_i,
      output req_adr_i,
      output req_dat_i,
      input  req_ready_o
   );

   modport slave (
      input  req_valid_i,
      input  req_cmd_i,
      input  req_adr_i,
      input  req_dat_i,
      output req_ready_o
   );

endinterface

// File: rtl/coeff_load_sequencer_rr_arb2.sv
// Two-input round-robin arbiter; owns last_grant, which moves only on
// an accept so a stalled tie keeps favouring the same requester.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] valid,
   input  logic       en,
   output logic       grant,
   output logic       accept
);

   logic last_grant;

   // On a tie the requester not granted last wins
   assign grant  = valid[1] & (~valid[0] | ~last_grant);
   assign accept = en & (|valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
      end else if (accept) begin
         last_grant <= grant;
      end
   end

endmodule

// File: rtl/coeff_load_sequencer.sv
// Arbitrates two coefficient requesters onto one held-strobe write bus.
// Define COEFF_SEQ_SHADOW_EN to add a 256x18 shadow readback RAM.
module coeff_load_sequencer
   import coeff_seq_pkg::*;
#(
   parameter int HOLD_CYCLES = 32
) (
   input  logic                   aclk,
   input  logic                   reset,
   coeff_load_sequencer_if.slave  req,
   output logic                   done_o,
   output logic                   done_id_o,
   output logic                   busy_o,
   output logic [COEFF_ADR_W-1:0] coeff_adr_o,
   output logic [COEFF_DAT_W-1:0] coeff_dat_o,
   output logic                   coeff_wr_o,
   output logic                   coeff_update_o
`ifdef COEFF_SEQ_SHADOW_EN
   ,
   input  logic [COEFF_ADR_W-1:0] shadow_adr_i,
   output logic [COEFF_DAT_W-1:0] shadow_dat_o
`endif
);

   seq_state_t             state;
   logic [7:0]             hold_cnt;
   logic                   gnt_q;
   logic                   grant;
   logic                   accept;
   logic                   cmd_sel;
   logic [COEFF_ADR_W-1:0] adr_sel;
   logic [COEFF_DAT_W-1:0] dat_sel;

   rr_arb2 u_arb (
      .clk    (aclk),
      .reset  (reset),
      .valid  (req.req_valid_i),
      .en     ((state == IDLE) && !reset),
      .grant  (grant),
      .accept (accept)
   );

   assign req.req_ready_o =
      accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

   assign cmd_sel = req.req_cmd_i[grant];
   assign adr_sel = grant ? req.req_adr_i[15:8]
                          : req.req_adr_i[7:0];
   assign dat_sel = grant ? req.req_dat_i[35:18]
                          : req.req_dat_i[17:0];

   always_ff @(posedge aclk) begin
      if (reset) begin
         state          <= IDLE;
         hold_cnt       <= '0;
         gnt_q          <= 1'b0;
         done_o         <= 1'b0;
         done_id_o      <= 1'b0;
         busy_o         <= 1'b0;
         coeff_adr_o    <= '0;
         coeff_dat_o    <= '0;
         coeff_wr_o     <= 1'b0;
         coeff_update_o <= 1'b0;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state    <= HOLD;
                  hold_cnt <= 8'(HOLD_CYCLES - 1);
                  gnt_q    <= grant;
                  busy_o   <= 1'b1;
                  if (cmd_sel == CMD_WRITE) begin
                     coeff_adr_o <= adr_sel;
                     coeff_dat_o <= dat_sel;
                     coeff_wr_o  <= 1'b1;
                  end else begin
                     coeff_update_o <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (hold_cnt == 8'd0) begin
                  state          <= GAP;
                  coeff_wr_o     <= 1'b0;
                  coeff_update_o <= 1'b0;
                  done_o         <= 1'b1;
                  done_id_o      <= gnt_q;
               end else begin
                  hold_cnt <= hold_cnt - 8'd1;
               end
            end
            GAP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef COEFF_SEQ_SHADOW_EN
   logic [COEFF_DAT_W-1:0] shadow_mem [256];
   logic                   wr_acc;

   assign wr_acc = accept && (cmd_sel == CMD_WRITE);

   // Write-through bypass so a same-edge readback sees the new data
   always_ff @(posedge aclk) begin
      if (wr_acc) begin
         shadow_mem[adr_sel] <= dat_sel;
      end
      if (wr_acc && (adr_sel == shadow_adr_i)) begin
         shadow_dat_o <= dat_sel;
      end else begin
         shadow_dat_o <= shadow_mem[shadow_adr_i];
      end
   end
`endif

endmodule

// File: doc/coeff_load_sequencer.md
# coeff_load_sequencer

Sequences biquad coefficient loads in the `aclk` domain. Two requesters share the single coefficient write bus that feeds the recursive biquads and the gain/zero stage: requester 0 is the CPU-side bridge and requester 1 is the default-coefficient boot loader. The block round-robin arbitrates between them. It holds each write or update strobe for a programmable number of clocks, because the filters need multiple cycles to absorb a coefficient. It then reports completion to the winning requester.

## Interface
Parameters:
- `HOLD_CYCLES`, default 32: cycles each `coeff_wr_o`/`coeff_update_o` strobe is held. Legal range 1..255.

Ports (one clock; reset is synchronous and active-high):
- `aclk` input 1: sole clock.
- `reset` input 1: synchronous, active-high.
- `req_valid_i` input [1:0]: per-requester request valid.
- `req_ready_o` output [1:0]: per-requester accept. At most one bit high.
- `req_cmd_i` input [1:0]: per-requester command. 0 = write, 1 = update.
- `req_adr_i` input [15:0]: {req1[7:0], req0[7:0]} coefficient address.
- `req_dat_i` input [35:0]: {req1[17:0], req0[17:0]} coefficient data.
- `done_o` output 1: one-cycle completion pulse.
- `done_id_o` output 1: requester that `done_o` refers to.
- `busy_o` output 1: high whenever state is not IDLE.
- `coeff_adr_o` output 8: to filters.
- `coeff_dat_o` output 18: to filters.
- `coeff_wr_o` output 1: write strobe, held.
- `coeff_update_o` output 1: update-all strobe, held.
- `shadow_adr_i` input 8, and `shadow_dat_o` output 18: readback port. Present only with COEFF_SEQ_SHADOW_EN.

## Operation
- States:
  - IDLE: accepts a request.
  - HOLD: strobe active; `hold_cnt` counts down.
  - GAP: one cycle with strobes low; `done_o` pulses.
  - GAP always returns to IDLE.
- Arbitration:
  - In IDLE, `req_ready_o[g]` is combinationally high for grant `g`.
  - If only one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - `last_grant` updates only on an accept.
- Handshake is valid/ready:
  - A requester holds valid, cmd, adr and dat stable until ready.
  - A request is accepted when valid and ready are both high on a rising edge.
  - After acceptance the requester may drop valid or present a new request.
- On accept with cmd = write:
  - Latch adr/dat into `coeff_adr_o`/`coeff_dat_o`.
  - Assert `coeff_wr_o`; `coeff_update_o` stays low.
- On accept with cmd = update:
  - Assert `coeff_update_o`; `coeff_wr_o` stays low.
  - `coeff_adr_o`/`coeff_dat_o` keep their previous values.
- Counter: `hold_cnt` is loaded with HOLD_CYCLES-1 on accept and decrements in HOLD. HOLD exits at 0. Its width is 8 bits; it never wraps.
- HOLD to GAP transition: deassert both strobes and pulse `done_o`, with `done_id_o` set to the latched grant.
- `coeff_adr_o`/`coeff_dat_o` remain stable from accept until the next write accept.
- Reset takes effect on the next edge, regardless of state:
  - State returns to IDLE.
  - Strobes, `done_o`, `busy_o`, `coeff_adr_o` and `coeff_dat_o` all go to 0.
  - `last_grant` is set to 1, so requester 0 wins the first tie.
  - An in-flight request is dropped with no `done_o`.
  - `req_ready_o` is 0 while `reset` is high.

## Timing
- Accept on edge N.
- Strobe and outputs are valid from N+1 through N+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles.
- GAP and `done_o` fall in cycle N+HOLD_CYCLES+1.
- Earliest next accept is edge N+HOLD_CYCLES+2. Throughput is one request per HOLD_CYCLES+2 cycles.
- `coeff_wr_o` and `coeff_update_o` are never high in the same cycle. Each is always followed by at least one low cycle.
- `req_ready_o` is combinational from state, `req_valid_i` and `last_grant`. All other outputs are registered.

## Configuration
- `COEFF_SEQ_SHADOW_EN` defined:
  - A 256x18 shadow RAM is written with adr/dat on every write accept.
  - `shadow_dat_o` is the registered RAM read at `shadow_adr_i`, with 1-cycle latency.
  - A readback of an address returns the new value starting from the cycle after the accept edge of a write to it.
  - RAM contents are not cleared by reset.
- Undefined: the shadow ports and RAM are absent. All other behaviour is identical.

## Structure
- Package `coeff_seq_pkg` holds:
  - State enum (IDLE/HOLD/GAP).
  - Command constants CMD_WRITE = 0 and CMD_UPDATE = 1.
  - Width constants COEFF_ADR_W = 8 and COEFF_DAT_W = 18.
- Sub-module `rr_arb2`: a two-input round-robin arbiter. Inputs are valid[1:0] and an enable; it outputs the grant index and owns the `last_grant` register, which updates on the accept strobe.

## Test plan
- Single write: req0 cmd = 0, adr = 0x12, dat = 0x2ABCD, HOLD_CYCLES = 32.
  - Expect `req_ready_o` = 01 for 1 cycle.
  - `coeff_wr_o` high for exactly 32 cycles with adr 0x12 and dat 0x2ABCD.
  - `done_o`/`done_id_o` = 1/0 on the 33rd cycle after accept.
- Update: req1 cmd = 1.
  - Expect `coeff_update_o` high for 32 cycles and `coeff_wr_o` low throughout.
  - adr/dat unchanged from the previous write.
  - `done_id_o` = 1.
- Contention: both requesters valid continuously after reset.
  - Expect grants in the order 0, 1, 0, 1.
  - Accepts spaced 34 cycles apart; no strobe overlap.
- Reset mid-HOLD: assert `reset` at cycle 10 of a write.
  - Expect all outputs 0 on the next edge and no `done_o`.
  - After release, a tie grants requester 0.
- HOLD_CYCLES = 1 boundary: back-to-back req0 writes.
  - Expect 1-cycle strobes and accepts every 3 cycles.
- COEFF_SEQ_SHADOW_EN: write adr 0x80, dat 0x3FFFF, then read at 0x80.
  - Expect `shadow_dat_o` = 0x3FFFF one cycle after `shadow_adr_i` is applied.
